obstacle_scroller: RTL and testbench
====================================

// Module: obstacle_scroller
// PURPOSE
//  Consumer end of the obstacle-selection handshake. Latches the obstacle type and width
//  offered by the selector, scrolls the obstacle right-to-left one speed step per frame
//  tick, and pulses obst_req when the obstacle fully leaves the screen. That pulse makes
//  the selector advance to the next type. Feeds position/height to renderer and collision.
// PARAMETERS
//  SCREEN_W     640  visible width in pixels; new obstacle's left edge starts here
//  GROUND_Y     400  y of ground line; cactus top = GROUND_Y - height
//  BIRD_Y       300  fixed top y of bird obstacle
//  SPEED_INIT   4    initial scroll speed, pixels/tick
//  SPEED_MAX    12   speed saturation value
//  SPEED_STEP   4    obstacles passed per +1 speed
//  LOAD_WAIT    2    clk cycles from obst_req fall to sampling obst_sel/obst_width
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  tick         in   1   frame strobe, 1 clk wide
//  gamestate    in   2   00 UnBegin, 01 Running, 11 Dead (10 treated as Dead)
//  obst_sel     in   4   offered type: 1000 bird, 0100/0101/0110/0111 cac1S/1B/2S/2B
//  obst_width   in   10  offered obstacle width in pixels (1..SCREEN_W)
//  obst_req     out  1   request next obstacle, 1 clk high pulse
//  cur_sel      out  4   latched type of obstacle on screen
//  obst_x       out  11  signed left edge x (may go negative)
//  obst_y       out  10  top y of obstacle
//  obst_h       out  8   height: 70 small cactus/bird, 100 big cactus
//  obst_visible out  1   1 when any part of the obstacle is on screen
//  speed        out  4   current scroll speed
//  passed_cnt   out  16  obstacles fully passed this game, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: state IDLE; cur_sel=0111, width reg=100, right edge xr=SCREEN_W+100;
//    speed=SPEED_INIT; passed_cnt=0; obst_req=0; obst_visible=0.
//  - Internal xr = right edge, 11-bit unsigned. obst_x = xr - width (signed 11).
//  - obst_visible = (xr > 0) && (obst_x < SCREEN_W).
//  - FSM IDLE / MOVE / REQ / WAIT, all transitions on clk rising edge.
//  - IDLE: each clk samples obst_sel/obst_width, sets xr=SCREEN_W+obst_width,
//    speed=SPEED_INIT, passed_cnt=0. gamestate==01 -> MOVE.
//  - MOVE, on tick: if xr <= speed then xr=0, passed_cnt+1 (saturating) -> REQ.
//    Otherwise xr -= speed. With no tick, xr holds.
//  - Speed update: when the new passed_cnt is a nonzero multiple of SPEED_STEP,
//    speed = min(speed+1, SPEED_MAX) in the same cycle.
//  - REQ: obst_req=1 for exactly 1 clk, then -> WAIT.
//  - WAIT: count LOAD_WAIT clks. Then latch obst_sel/obst_width into cur_sel/width,
//    set xr=SCREEN_W+obst_width -> MOVE. Ticks during REQ/WAIT are ignored.
//  - obst_y: BIRD_Y when cur_sel==1000, else GROUND_Y - obst_h.
//    Unknown sel gives obst_h=100.
//  - gamestate Dead (11/10), any state: all registers freeze, no tick is consumed.
//    If entered while in REQ, the pulse still completes its 1 clk. Then the FSM
//    freezes in WAIT.
//  - gamestate 00 from any state -> IDLE next clk, which performs the IDLE loads.
//  - Reset mid-operation returns everything to reset values, with no stray obst_req.
//  - tick and a gamestate change in the same clk: gamestate wins and the tick is dropped.
// TESTING
//  - Reset then gamestate=01, obst_width=100, 160 ticks -> xr=740-4k.
//    After tick 185, xr reaches 0; obst_req high exactly 1 clk, passed_cnt=1.
//  - Change obst_sel to 1000 and obst_width to 92 one clk after obst_req.
//    After LOAD_WAIT clks: cur_sel=1000, obst_x=640, obst_y=300, obst_h=70.
//  - Run 4 full obstacles -> speed 4->5 at passed_cnt=4.
//    Run 32 obstacles -> speed=12 and holds at 12 thereafter.
//  - gamestate=11 mid-MOVE with xr=300, 50 ticks -> xr stays 300, obst_req stays 0.
//    Back to 01 -> motion resumes from 300.
//  - gamestate 11->00 -> next clk IDLE, passed_cnt=0, speed=4, xr=SCREEN_W+obst_width.
//  - Assert rst_n=0 during WAIT -> obst_req=0 and reset values immediately (asynchronous).
//    No obst_req pulse after release until the next screen exit.

Source files
------------

// File: rtl/obstacle_scroller.sv
// -----------------------------------------------------------------------------
// obstacle_scroller
//
// Consumer side of the obstacle-selection handshake. Latches the obstacle type
// and width offered by the selector, scrolls the obstacle right-to-left by the
// current speed on every frame tick, and pulses obst_req for one clock when the
// obstacle has completely left the screen so the selector advances.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick         frame strobe, one clk wide
//   gamestate    00 UnBegin, 01 Running, 1x Dead
//   obst_sel     offered type (1000 bird, 0100/0101/0110/0111 cactus 1S/1B/2S/2B)
//   obst_width   offered obstacle width in pixels
//   obst_req     one-clock request for the next obstacle
//   cur_sel      type of the obstacle currently on screen
//   obst_x       signed left edge x (goes negative while leaving)
//   obst_y       top y of the obstacle
//   obst_h       obstacle height
//   obst_visible high while any part of the obstacle is on screen
//   speed        current scroll speed in pixels per tick
//   passed_cnt   obstacles fully passed this game (saturating)
// -----------------------------------------------------------------------------
module obstacle_scroller #(
    parameter int SCREEN_W   = 640,
    parameter int GROUND_Y   = 400,
    parameter int BIRD_Y     = 300,
    parameter int SPEED_INIT = 4,
    parameter int SPEED_MAX  = 12,
    parameter int SPEED_STEP = 4,
    parameter int LOAD_WAIT  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [1:0]         gamestate,
    input  logic [3:0]         obst_sel,
    input  logic [9:0]         obst_width,
    output logic               obst_req,
    output logic [3:0]         cur_sel,
    output logic signed [10:0] obst_x,
    output logic [9:0]         obst_y,
    output logic [7:0]         obst_h,
    output logic               obst_visible,
    output logic [3:0]         speed,
    output logic [15:0]        passed_cnt
);

    localparam logic [10:0] SCREEN_W_X   = 11'(SCREEN_W);
    localparam logic [9:0]  GROUND_Y_Y   = 10'(GROUND_Y);
    localparam logic [9:0]  BIRD_Y_Y     = 10'(BIRD_Y);
    localparam logic [3:0]  SPEED_INIT_V = 4'(SPEED_INIT);
    localparam logic [3:0]  SPEED_MAX_V  = 4'(SPEED_MAX);
    localparam int          WCW          = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(LOAD_WAIT - 1);

    typedef enum logic [1:0] {IDLE, MOVE, REQ, WAIT} state_t;

    state_t          state_reg,  state_next;
    logic [3:0]      sel_reg,    sel_next;
    logic [9:0]      width_reg,  width_next;
    logic [10:0]     xr_reg,     xr_next;      // right edge, unsigned
    logic [3:0]      speed_reg,  speed_next;
    logic [15:0]     passed_reg, passed_next;
    logic [WCW-1:0]  wait_reg,   wait_next;
    logic [1:0]      gs_prev_reg;              // detects gamestate changes

    logic        gs_run, gs_idle, tick_ok, load_new, restart, step_hit;
    logic [15:0] passed_inc;
    logic [3:0]  speed_inc;

    assign gs_run  = (gamestate == 2'b01);
    assign gs_idle = (gamestate == 2'b00);
    // A tick coinciding with a gamestate change is dropped.
    assign tick_ok = tick && gs_run && (gs_prev_reg == 2'b01);

    assign passed_inc = (passed_reg == 16'hFFFF) ? passed_reg : passed_reg + 16'd1;
    assign step_hit   = (passed_inc != 16'd0) && ((32'(passed_inc) % SPEED_STEP) == 0);
    assign speed_inc  = (speed_reg < SPEED_MAX_V) ? speed_reg + 4'd1 : speed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sel_reg     <= 4'b0111;
            width_reg   <= 10'd100;
            xr_reg      <= SCREEN_W_X + 11'd100;
            speed_reg   <= SPEED_INIT_V;
            passed_reg  <= 16'd0;
            wait_reg    <= '0;
            gs_prev_reg <= 2'b00;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            width_reg   <= width_next;
            xr_reg      <= xr_next;
            speed_reg   <= speed_next;
            passed_reg  <= passed_next;
            wait_reg    <= wait_next;
            gs_prev_reg <= gamestate;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        width_next  = width_reg;
        xr_next     = xr_reg;
        speed_next  = speed_reg;
        passed_next = passed_reg;
        wait_next   = wait_reg;
        load_new    = 1'b0;
        restart     = 1'b0;

        if (gs_idle) begin
            state_next = IDLE;
            load_new   = 1'b1;
            restart    = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Dead while idle simply holds everything.
                    if (gs_run) begin
                        state_next = MOVE;
                        load_new   = 1'b1;
                        restart    = 1'b1;
                    end
                end
                MOVE: begin
                    if (tick_ok) begin
                        if (xr_reg <= {7'd0, speed_reg}) begin
                            xr_next     = 11'd0;
                            passed_next = passed_inc;
                            if (step_hit) begin
                                speed_next = speed_inc;
                            end
                            state_next  = REQ;
                        end else begin
                            xr_next = xr_reg - {7'd0, speed_reg};
                        end
                    end
                end
                REQ: begin
                    // The request pulse always completes, even if Dead.
                    state_next = WAIT;
                    wait_next  = '0;
                end
                WAIT: begin
                    if (gs_run) begin
                        if (wait_reg == WAIT_LAST) begin
                            state_next = MOVE;
                            load_new   = 1'b1;
                        end else begin
                            wait_next = wait_reg + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (load_new) begin
            sel_next   = obst_sel;
            width_next = obst_width;
            xr_next    = SCREEN_W_X + {1'b0, obst_width};
        end
        if (restart) begin
            speed_next  = SPEED_INIT_V;
            passed_next = 16'd0;
            wait_next   = '0;
        end
    end

    // Bird and single/double small cacti are short; everything else is tall.
    always_comb begin
        case (sel_reg)
            4'b1000, 4'b0100, 4'b0110: obst_h = 8'd70;
            default:                   obst_h = 8'd100;
        endcase
    end

    assign obst_req     = (state_reg == REQ);
    assign cur_sel      = sel_reg;
    assign obst_x       = $signed(xr_reg - {1'b0, width_reg});
    assign obst_y       = (sel_reg == 4'b1000) ? BIRD_Y_Y : GROUND_Y_Y - {2'b00, obst_h};
    assign obst_visible = (xr_reg != 11'd0) && (obst_x < $signed(SCREEN_W_X));
    assign speed        = speed_reg;
    assign passed_cnt   = passed_reg;

endmodule

// File: tb/tb_obstacle_scroller.sv
module tb_obstacle_scroller;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic [1:0]         gamestate = 2'b00;
    logic [3:0]         obst_sel = 4'b0111;
    logic [9:0]         obst_width = 10'd100;
    logic               obst_req;
    logic [3:0]         cur_sel;
    logic signed [10:0] obst_x;
    logic [9:0]         obst_y;
    logic [7:0]         obst_h;
    logic               obst_visible;
    logic [3:0]         speed;
    logic [15:0]        passed_cnt;

    obstacle_scroller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .gamestate    (gamestate),
        .obst_sel     (obst_sel),
        .obst_width   (obst_width),
        .obst_req     (obst_req),
        .cur_sel      (cur_sel),
        .obst_x       (obst_x),
        .obst_y       (obst_y),
        .obst_h       (obst_h),
        .obst_visible (obst_visible),
        .speed        (speed),
        .passed_cnt   (passed_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Height from the obstacle type table.
    function automatic int h_of(input logic [3:0] sel);
        if (sel == 4'b1000 || sel == 4'b0100 || sel == 4'b0110) return 70;
        return 100;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int         ticks;
        int         passed;
        int         spd;
        int         width;
        logic [3:0] sel;
    } exp_t;
    exp_t sb[$];

    bit         mon_en = 1'b0;
    int         tick_total = 0;
    int         last_total = 0;
    logic [1:0] gs_hist = 2'b00;

    // A tick counts only while Running and gamestate did not just change.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs_hist <= 2'b00;
        end else begin
            if (tick && gamestate == 2'b01 && gs_hist == 2'b01)
                tick_total <= tick_total + 1;
            gs_hist <= gamestate;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            last_total = tick_total;
        end else if (obst_req) begin
            if (sb.size() == 0) begin
                check("unexpected_req", 1, 0);
            end else begin
                e = sb.pop_front();
                check("exit_ticks", tick_total - last_total, e.ticks);
                check("exit_passed", int'(passed_cnt), e.passed);
                check("exit_speed", int'(speed), e.spd);
                check("exit_x", int'(obst_x), -e.width);
                check("exit_sel", int'(cur_sel), int'(e.sel));
                check("exit_h", int'(obst_h), h_of(e.sel));
                $display("obstacle exit: width=%0d sel=%b ticks=%0d passed=%0d speed=%0d",
                         e.width, e.sel, tick_total - last_total, passed_cnt, speed);
            end
            last_total = tick_total;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_ticks(input int n, output int reqs);
        reqs = 0;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            if (obst_req) reqs++;
            @(negedge clk);
            if (obst_req) reqs++;
        end
    endtask

    logic [3:0] sel_tab [5] = '{4'b1000, 4'b0100, 4'b0101, 4'b0110, 4'b0111};

    int m_speed, m_passed;

    // Predict the exit of an obstacle offered now, then advance the model.
    task automatic offer(input logic [3:0] sel, input int w);
        exp_t e;
        obst_sel   = sel;
        obst_width = 10'(w);
        e.ticks    = (640 + w + m_speed - 1) / m_speed;
        if (m_passed < 65535) m_passed++;
        if (m_passed % 4 == 0 && m_speed < 12) m_speed++;
        e.passed = m_passed;
        e.spd    = m_speed;
        e.width  = w;
        e.sel    = sel;
        sb.push_back(e);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int reqs, n, got;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        check("rst_req", int'(obst_req), 0);
        check("rst_sel", int'(cur_sel), 7);
        check("rst_x", int'(obst_x), 640);
        check("rst_speed", int'(speed), 4);
        check("rst_passed", int'(passed_cnt), 0);
        check("rst_visible", int'(obst_visible), 0);
        check("rst_h", int'(obst_h), 100);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- first obstacle, width 100 ----
        obst_sel = 4'b0111; obst_width = 10'd100; gamestate = 2'b01;
        @(negedge clk);
        do_ticks(160, reqs);
        check("x_after_160", int'(obst_x), 0);
        check("vis_after_160", int'(obst_visible), 1);
        do_ticks(24, reqs);
        check("x_after_184", int'(obst_x), -96);
        check("no_req_before_185", reqs, 0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("req_at_185", int'(obst_req), 1);
        check("passed_at_185", int'(passed_cnt), 1);
        check("x_at_exit", int'(obst_x), -100);
        check("vis_at_exit", int'(obst_visible), 0);
        @(negedge clk);
        check("req_one_clk", int'(obst_req), 0);
        obst_sel = 4'b1000; obst_width = 10'd92;
        @(negedge clk);
        check("sel_before_load", int'(cur_sel), 7);
        @(negedge clk);
        check("bird_sel", int'(cur_sel), 8);
        check("bird_x", int'(obst_x), 640);
        check("bird_y", int'(obst_y), 300);
        check("bird_h", int'(obst_h), 70);

        // ---- Dead freeze at xr=300 ----
        do_ticks(108, reqs);
        check("x_at_300", int'(obst_x), 208);
        gamestate = 2'b11;
        do_ticks(50, reqs);
        check("dead_x_hold", int'(obst_x), 208);
        check("dead_no_req", reqs, 0);
        gamestate = 2'b01; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("tick_dropped_on_change", int'(obst_x), 208);
        do_ticks(1, reqs);
        check("resume_x", int'(obst_x), 204);

        // ---- Dead then UnBegin ----
        gamestate = 2'b11;
        @(negedge clk);
        obst_sel = 4'b0111; obst_width = 10'd50; gamestate = 2'b00;
        @(negedge clk);
        check("unbegin_passed", int'(passed_cnt), 0);
        check("unbegin_speed", int'(speed), 4);
        check("unbegin_x", int'(obst_x), 640);

        // ---- reset during WAIT ----
        gamestate = 2'b01;
        @(negedge clk);
        n = 0; got = 0;
        while (!got && n < 400) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            n++;
            if (obst_req) got = 1;
            else @(negedge clk);
        end
        check("ticks_to_exit_w50", n, 173);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_req", int'(obst_req), 0);
        check("arst_x", int'(obst_x), 640);
        check("arst_passed", int'(passed_cnt), 0);
        check("arst_speed", int'(speed), 4);
        @(negedge clk);
        rst_n = 1'b1;
        reqs = 0;
        repeat (30) begin
            @(negedge clk);
            if (obst_req) reqs++;
        end
        check("no_req_after_reset", reqs, 0);

        // ---- randomized run with scoreboard ----
        m_speed = 4; m_passed = 0;
        gamestate = 2'b00;
        offer(sel_tab[$urandom_range(0, 4)], $urandom_range(1, 640));
        mon_en = 1'b1;
        @(negedge clk);
        gamestate = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 36; k++) begin
            got = 0;
            for (int t = 0; t < 2000 && !got; t++) begin
                if ($urandom_range(0, 29) == 0) begin
                    gamestate = 2'b11;
                    repeat ($urandom_range(1, 4)) begin
                        tick = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    gamestate = 2'b01; tick = 1'b1;
                    @(negedge clk);
                    tick = 1'b0;
                end
                tick = 1'b1;
                @(negedge clk);
                tick = 1'b0;
                if (obst_req) got = 1;
                else repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            if (!got) begin
                check("exit_timeout", 0, 1);
                break;
            end
            if (k < 35) offer(sel_tab[$urandom_range(0, 4)], $urandom_range(1, 640));
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("final_speed", int'(speed), 12);
        check("scoreboard_empty", sb.size(), 0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
